pll_scan_receiver: RTL and testbench

//  Receiving end of the PLL reconfiguration scan chain. Captures the serial stream
//  (scan_ena/scan_data) into a shadow register and transfers it to decoded active

---
 rtl/pll_scan_receiver.sv | 178 +++++++++++++++++
 tb/tb_pll_scan_receiver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_scan_receiver.sv
// Receiving end of the PLL reconfiguration scan chain with an emulated lock response.
// Define SCAN_READBACK_EN to present the old shadow LSB-first on scan_dataout while shifting.
module pll_scan_receiver #(
  parameter int CHAIN_LEN   = 145,
  parameter int LOCK_CYCLES = 16
) (
  input  logic        scan_clk,
  input  logic        scan_rst_n,
  input  logic        scan_ena,
  input  logic        scan_data,
  input  logic        scan_update,
  input  logic        pll_rst,
  output logic [17:0] head_conf,
  output logic [17:0] m_conf,
  output logic [17:0] n_conf,
  output logic [17:0] clk0_conf,
  output logic [17:0] clk1_conf,
  output logic [17:0] clk2_conf,
  output logic [17:0] clk3_conf,
  output logic [17:0] clk4_conf,
  output logic        conf_valid,
  output logic        len_err,
  output logic        locked,
  output logic        scan_dataout
);

  localparam int                 LCW       = $clog2(LOCK_CYCLES + 1);
  localparam logic [7:0]         FULL_CNT  = 8'(CHAIN_LEN);
  localparam logic [LCW-1:0]     LOCK_INIT = LCW'(LOCK_CYCLES);
  localparam logic [17:0]        CONF_RST  = 18'h2_0000;

  typedef enum logic [1:0] {
    LOCKED    = 2'd0,
    UNLOCKED  = 2'd1,
    IN_RST    = 2'd2,
    WAIT_LOCK = 2'd3
  } lock_state_e;

  logic [CHAIN_LEN-1:0] sr_q;
  logic [7:0]           bit_cnt_q, bit_cnt_d;
  logic                 upd_q;
  logic [17:0]          conf_q [8];
  logic                 conf_valid_q;
  logic                 len_err_q;
  lock_state_e          state_q, state_d;
  logic [LCW-1:0]       lock_cnt_q, lock_cnt_d;
  logic                 locked_q;
  logic                 upd_edge_s;
  logic                 accept_s;
  logic                 shift_s;

  // Update-edge qualification and bit counter next state; an update edge always wins over shifting.
  always_comb begin
    upd_edge_s = scan_update & ~upd_q;
    accept_s   = upd_edge_s & ~scan_ena & (bit_cnt_q == FULL_CNT);
    shift_s    = scan_ena & ~upd_edge_s;
    bit_cnt_d  = bit_cnt_q;
    if (upd_edge_s) begin
      bit_cnt_d = 8'd0;
    end else if (shift_s && (bit_cnt_q != 8'hFF)) begin
      bit_cnt_d = bit_cnt_q + 8'd1;
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Lock FSM next state: pll_rst dominates, an accepted load drops lock until the next pll_rst.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (pll_rst) begin
      state_d = IN_RST;
    end else begin
      case (state_q)
        IN_RST: begin
          state_d    = WAIT_LOCK;
          lock_cnt_d = LOCK_INIT;
        end
        WAIT_LOCK: begin
          if (accept_s) begin
            state_d = UNLOCKED;
          end else if (lock_cnt_q == LCW'(1)) begin
            state_d = LOCKED;
          end else begin
            lock_cnt_d = lock_cnt_q - LCW'(1);
          end
        end
        LOCKED: begin
          if (accept_s) begin
            state_d = UNLOCKED;
          end else begin
            state_d = LOCKED;
          end
        end
        UNLOCKED: begin
          state_d = UNLOCKED;
        end
        default: begin
          state_d    = WAIT_LOCK;
          lock_cnt_d = LOCK_INIT;
        end
      endcase
    end
  end

  // Shadow register, decoded active fields, status flags and lock state.
  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      sr_q         <= '0;
      bit_cnt_q    <= 8'd0;
      upd_q        <= 1'b0;
      conf_valid_q <= 1'b0;
      len_err_q    <= 1'b0;
      state_q      <= WAIT_LOCK;
      lock_cnt_q   <= LOCK_INIT;
      locked_q     <= 1'b0;
      for (int f = 0; f < 8; f++) begin
        conf_q[f] <= CONF_RST;
      end
    end else begin
      if (shift_s) begin
        sr_q <= {scan_data, sr_q[CHAIN_LEN-1:1]};
      end else begin
        sr_q <= sr_q;
      end
      bit_cnt_q    <= bit_cnt_d;
      upd_q        <= scan_update;
      conf_valid_q <= accept_s;
      if (upd_edge_s) begin
        len_err_q <= ~accept_s;
      end else begin
        len_err_q <= len_err_q;
      end
      for (int f = 0; f < 8; f++) begin
        if (accept_s) begin
          conf_q[f] <= sr_q[CHAIN_LEN-1-18*f -: 18];
        end else begin
          conf_q[f] <= conf_q[f];
        end
      end
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= (state_d == LOCKED);
    end
  end

`ifdef SCAN_READBACK_EN
  logic dout_q;

  // Readback: one cycle behind the shadow LSB, so a full shift replays the previous load in order.
  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      dout_q <= 1'b0;
    end else begin
      dout_q <= sr_q[0];
    end
  end

  assign scan_dataout = dout_q;
`else
  logic pad_unused_s;
  assign pad_unused_s = sr_q[0];
  assign scan_dataout = 1'b0;
`endif

  assign head_conf  = conf_q[0];
  assign m_conf     = conf_q[1];
  assign n_conf     = conf_q[2];
  assign clk0_conf  = conf_q[3];
  assign clk1_conf  = conf_q[4];
  assign clk2_conf  = conf_q[5];
  assign clk3_conf  = conf_q[6];
  assign clk4_conf  = conf_q[7];
  assign conf_valid = conf_valid_q;
  assign len_err    = len_err_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_pll_scan_receiver.sv
// Bench for pll_scan_receiver: directed scan loads checked against a bit-history model every cycle.
module tb_pll_scan_receiver;

  localparam int CHAIN = 145;
  localparam int LOCKC = 16;
  localparam int IN_RST_MARK = LOCKC + 1;

  logic        scan_clk = 1'b0;
  logic        scan_rst_n, scan_ena, scan_data, scan_update, pll_rst;
  logic [17:0] head_conf, m_conf, n_conf, clk0_conf, clk1_conf, clk2_conf, clk3_conf, clk4_conf;
  logic        conf_valid, len_err, locked, scan_dataout;

  pll_scan_receiver #(.CHAIN_LEN(CHAIN), .LOCK_CYCLES(LOCKC)) dut (
    .scan_clk(scan_clk), .scan_rst_n(scan_rst_n), .scan_ena(scan_ena), .scan_data(scan_data),
    .scan_update(scan_update), .pll_rst(pll_rst),
    .head_conf(head_conf), .m_conf(m_conf), .n_conf(n_conf),
    .clk0_conf(clk0_conf), .clk1_conf(clk1_conf), .clk2_conf(clk2_conf),
    .clk3_conf(clk3_conf), .clk4_conf(clk4_conf),
    .conf_valid(conf_valid), .len_err(len_err), .locked(locked), .scan_dataout(scan_dataout)
  );

  always #5 scan_clk = ~scan_clk;

  int total = 0;
  int bad   = 0;

  // Model: every bit ever shifted since reset; the shadow is simply the newest CHAIN of them.
  bit          hist[$];
  int          m_cnt;
  bit          m_upd;
  int          m_eta;
  bit          m_unlocked;
  logic [17:0] e_conf [8];
  bit          e_valid, e_len_err, e_locked, e_dout;

  logic [144:0] ch_a, ch_b, ch_c, got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit chain_bit(input int k);
    int idx;
    idx = hist.size() - CHAIN + k;
    return (idx >= 0) ? hist[idx] : 1'b0;
  endfunction

  function automatic logic [17:0] field_of(input int f);
    logic [17:0] r;
    for (int b = 0; b < 18; b++) r[b] = chain_bit(CHAIN - 18 - 18 * f + b);
    return r;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_cnt = 0; m_upd = 1'b0; m_eta = LOCKC; m_unlocked = 1'b0;
    for (int f = 0; f < 8; f++) e_conf[f] = 18'h2_0000;
    e_valid = 1'b0; e_len_err = 1'b0; e_locked = 1'b0; e_dout = 1'b0;
  endtask

  task automatic model_step();
    bit upd_edge_b, acc_b;
    upd_edge_b = scan_update && !m_upd;
    acc_b      = upd_edge_b && !scan_ena && (m_cnt == CHAIN);
`ifdef SCAN_READBACK_EN
    e_dout = chain_bit(0);
`else
    e_dout = 1'b0;
`endif
    if (acc_b) for (int f = 0; f < 8; f++) e_conf[f] = field_of(f);
    if (scan_ena && !upd_edge_b) begin
      hist.push_back(scan_data);
      if (m_cnt < 255) m_cnt++;
    end
    if (upd_edge_b) begin
      m_cnt = 0;
      e_len_err = !acc_b;
    end
    e_valid = acc_b;
    m_upd = scan_update;
    // m_eta counts edges still needed before lock; IN_RST_MARK means held in PLL reset.
    if (pll_rst) begin
      m_eta = IN_RST_MARK;
      m_unlocked = 1'b0;
    end else begin
      if (acc_b && m_eta != IN_RST_MARK) m_unlocked = 1'b1;
      if (m_eta > 0) m_eta--;
    end
    e_locked = !pll_rst && (m_eta == 0) && !m_unlocked;
  endtask

  task automatic compare_all();
    chk("head", head_conf, e_conf[0]);
    chk("m", m_conf, e_conf[1]);
    chk("n", n_conf, e_conf[2]);
    chk("clk0", clk0_conf, e_conf[3]);
    chk("clk1", clk1_conf, e_conf[4]);
    chk("clk2", clk2_conf, e_conf[5]);
    chk("clk3", clk3_conf, e_conf[6]);
    chk("clk4", clk4_conf, e_conf[7]);
    chk("conf_valid", conf_valid, e_valid);
    chk("len_err", len_err, e_len_err);
    chk("locked", locked, e_locked);
    chk("scan_dataout", scan_dataout, e_dout);
  endtask

  // Inputs only change just after a rising edge, so at the falling edge they are the next-edge values.
  initial begin
    forever begin
      @(negedge scan_clk);
      if (!scan_rst_n) begin
        model_reset();
      end else begin
        compare_all();
        model_step();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge scan_clk);
    #1;
  endtask

  task automatic shift_bits(input logic [144:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      scan_ena = 1'b1; scan_data = v[i];
      tick();
    end
    scan_ena = 1'b0; scan_data = 1'b0;
  endtask

  task automatic wait_lock(input string name, input int exp_n);
    int n;
    n = 0;
    while (!locked && n < 40) begin
      tick();
      n++;
    end
    chk(name, n, exp_n);
  endtask

  initial begin
    ch_a = {18'h0D801, 18'h00A05, 18'h00101, 18'h00202, 18'h00203, 18'h00204, 18'h00205, 18'h00206, 1'b0};
    ch_b = {18'h3FFFF, 18'h12345, 18'h2AAAA, 18'h15555, 18'h00F0F, 18'h3C3C3, 18'h01234, 18'h0ABCD, 1'b1};
    ch_c = {18'h11111, 18'h22222, 18'h03333, 18'h04444, 18'h05555, 18'h06666, 18'h07777, 18'h08888, 1'b0};
    scan_rst_n = 1'b0; scan_ena = 1'b0; scan_data = 1'b0; scan_update = 1'b0; pll_rst = 1'b0;
    repeat (3) tick();
    scan_rst_n = 1'b1;

    // Reset state and lock after reset release
    chk("rst_head", head_conf, 18'h2_0000);
    chk("rst_clk4", clk4_conf, 18'h2_0000);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_locked", locked, 1'b0);
    wait_lock("lock_after_reset", 16);

    // Good load A
    shift_bits(ch_a, 145);
    scan_update = 1'b1; tick();
    chk("a_valid", conf_valid, 1'b1);
    chk("a_head", head_conf, 18'h0D801);
    chk("a_m", m_conf, 18'h00A05);
    chk("a_n", n_conf, 18'h00101);
    chk("a_clk0", clk0_conf, 18'h00202);
    chk("a_clk4", clk4_conf, 18'h00206);
    chk("a_unlocked", locked, 1'b0);
    chk("model_head_a", e_conf[0], 18'h0D801);
    chk("model_clk4_a", e_conf[7], 18'h00206);
    scan_update = 1'b0; tick();
    chk("a_valid_pulse_end", conf_valid, 1'b0);
    pll_rst = 1'b1; tick(); tick();
    pll_rst = 1'b0;
    chk("in_rst_locked", locked, 1'b0);
    wait_lock("lock_after_pll_rst", 17);

    // Short load (144 bits) rejected, then full load B accepted
    shift_bits(ch_b, 144);
    scan_update = 1'b1; tick();
    chk("short_len_err", len_err, 1'b1);
    chk("short_no_valid", conf_valid, 1'b0);
    chk("short_head_kept", head_conf, 18'h0D801);
    scan_update = 1'b0; tick();
    shift_bits(ch_b, 145);
    scan_update = 1'b1; tick();
    chk("b_len_err_clr", len_err, 1'b0);
    chk("b_valid", conf_valid, 1'b1);
    chk("b_head", head_conf, 18'h3FFFF);
    chk("b_clk4", clk4_conf, 18'h0ABCD);
    scan_update = 1'b0; tick();

    // Update edge while shifting: rejected, counter cleared so a following 145-bit load works
    shift_bits(ch_c, 10);
    scan_ena = 1'b1; scan_data = 1'b1; scan_update = 1'b1; tick();
    chk("ena_len_err", len_err, 1'b1);
    chk("ena_no_valid", conf_valid, 1'b0);
    chk("ena_head_kept", head_conf, 18'h3FFFF);
    scan_ena = 1'b0; scan_data = 1'b0; scan_update = 1'b0; tick();
    shift_bits(ch_c, 145);
    scan_update = 1'b1; tick();
    chk("c_valid", conf_valid, 1'b1);
    chk("c_head", head_conf, 18'h11111);
    chk("c_clk3", clk3_conf, 18'h07777);
    scan_update = 1'b0; tick();

    // pll_rst reasserted mid-wait restarts the full wait
    pll_rst = 1'b1; tick();
    pll_rst = 1'b0;
    repeat (12) tick();
    chk("mid_wait_locked", locked, 1'b0);
    pll_rst = 1'b1; tick();
    pll_rst = 1'b0;
    wait_lock("lock_restart", 17);

`ifdef SCAN_READBACK_EN
    // Readback of load A while shifting B
    shift_bits(ch_a, 145);
    scan_update = 1'b1; tick();
    scan_update = 1'b0; tick();
    for (int i = 0; i < 145; i++) begin
      scan_ena = 1'b1; scan_data = ch_b[i];
      tick();
      got[i] = scan_dataout;
    end
    scan_ena = 1'b0;
    for (int i = 0; i < 145; i++) chk($sformatf("readback_bit%0d", i), got[i], ch_a[i]);
`endif

    // Async reset mid-shift discards the partial load
    shift_bits(ch_a, 50);
    scan_ena = 1'b1; scan_rst_n = 1'b0; tick(); tick();
    scan_ena = 1'b0; scan_rst_n = 1'b1;
    chk("arst_head", head_conf, 18'h2_0000);
    chk("arst_locked", locked, 1'b0);
    chk("arst_len_err", len_err, 1'b0);
    shift_bits(ch_a, 95);
    scan_update = 1'b1; tick();
    chk("arst_partial_rejected", len_err, 1'b1);
    scan_update = 1'b0; repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
